// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, colour type and test-pattern colours.
package vga_pkg;

    localparam int CLK_DIV  = 4;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int PIPE_DLY = 1;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CNT_W    = 10;

    typedef logic [11:0] rgb_t;

    // One pipeline stage: sync levels travel with the colour they belong to.
    typedef struct packed {
        logic hs;
        logic vs;
        rgb_t rgb;
    } pix_t;

    localparam pix_t PIX_IDLE = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};

    localparam rgb_t BAR_WHITE   = 12'hFFF;
    localparam rgb_t BAR_YELLOW  = 12'hFF0;
    localparam rgb_t BAR_CYAN    = 12'h0FF;
    localparam rgb_t BAR_GREEN   = 12'h0F0;
    localparam rgb_t BAR_MAGENTA = 12'hF0F;

    // Bars are 128 pixels wide, so only indices 0..4 fall in the visible area.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-tick divider plus horizontal/vertical raster counters, active-area flag,
// raw (undelayed) syncs and the frame-wrap pulse.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int P_CLK_DIV  = CLK_DIV,
    parameter int P_H_ACTIVE = H_ACTIVE,
    parameter int P_H_FP     = H_FP,
    parameter int P_H_SYNC   = H_SYNC,
    parameter int P_H_BP     = H_BP,
    parameter int P_V_ACTIVE = V_ACTIVE,
    parameter int P_V_FP     = V_FP,
    parameter int P_V_SYNC   = V_SYNC,
    parameter int P_V_BP     = V_BP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_valid,
    output logic             o_pix_tick,
    output logic             o_frame_start,
    output logic             o_hs_raw,
    output logic             o_vs_raw
);

    localparam int P_H_TOTAL = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP;
    localparam int P_V_TOTAL = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP;
    localparam int DIV_W     = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(P_CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(P_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(P_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(P_H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(P_V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(P_H_ACTIVE + P_H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(P_H_ACTIVE + P_H_FP + P_H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(P_V_ACTIVE + P_V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(P_V_ACTIVE + P_V_FP + P_V_SYNC);

    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_tick;
    logic             w_h_last;
    logic             w_v_last;

    assign w_tick   = (r_div == DIV_LAST);
    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_tick) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    assign o_h_cnt       = r_h_cnt;
    assign o_v_cnt       = r_v_cnt;
    assign o_pix_tick    = w_tick;
    assign o_valid       = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign o_frame_start = w_tick && w_h_last && w_v_last;
    assign o_hs_raw      = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
    assign o_vs_raw      = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));

endmodule

// File: rtl/vga_timing_out.sv
// VGA output stage: raster timing plus a PIPE_DLY-tick delay line that keeps syncs
// and blanked colour aligned at the pins. VGA_TEST_PATTERN_EN adds a colour-bar source.
module vga_timing_out
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = vga_pkg::CLK_DIV,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int PIPE_DLY = vga_pkg::PIPE_DLY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [11:0]      rgb_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             pattern_sel,
`endif
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             valid,
    output logic             pix_tick,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b
);

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_valid;
    logic             w_tick;
    logic             w_frame_start;
    logic             w_hs_raw;
    logic             w_vs_raw;
    rgb_t             w_colour;
    pix_t             w_stage_in;

    pix_t [PIPE_DLY-1:0] r_pipe;

    vga_sync_counter #(
        .P_CLK_DIV  (CLK_DIV),
        .P_H_ACTIVE (H_ACTIVE),
        .P_H_FP     (H_FP),
        .P_H_SYNC   (H_SYNC),
        .P_H_BP     (H_BP),
        .P_V_ACTIVE (V_ACTIVE),
        .P_V_FP     (V_FP),
        .P_V_SYNC   (V_SYNC),
        .P_V_BP     (V_BP)
    ) u_sync (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_h_cnt       (w_h_cnt),
        .o_v_cnt       (w_v_cnt),
        .o_valid       (w_valid),
        .o_pix_tick    (w_tick),
        .o_frame_start (w_frame_start),
        .o_hs_raw      (w_hs_raw),
        .o_vs_raw      (w_vs_raw)
    );

    // Blanking is applied at capture so no later stage can leak colour outside the active area.
    always_comb begin
        w_colour = rgb_in;
`ifdef VGA_TEST_PATTERN_EN
        if (pattern_sel) begin
            w_colour = bar_colour(w_h_cnt[9:7]);
        end
`endif
        w_stage_in = '{hs: w_hs_raw, vs: w_vs_raw, rgb: (w_valid ? w_colour : 12'h000)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                r_pipe[i] <= PIX_IDLE;
            end
        end else if (w_tick) begin
            r_pipe[0] <= w_stage_in;
            for (int i = 1; i < PIPE_DLY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign h_cnt       = w_h_cnt;
    assign v_cnt       = w_v_cnt;
    assign valid       = w_valid;
    assign pix_tick    = w_tick;
    assign frame_start = w_frame_start;
    assign hsync       = r_pipe[PIPE_DLY-1].hs;
    assign vsync       = r_pipe[PIPE_DLY-1].vs;
    assign vga_r       = r_pipe[PIPE_DLY-1].rgb[11:8];
    assign vga_g       = r_pipe[PIPE_DLY-1].rgb[7:4];
    assign vga_b       = r_pipe[PIPE_DLY-1].rgb[3:0];

endmodule

// File: tb/tb_vga_timing_out.sv
// Scoreboard bench for vga_timing_out: full horizontal timing, shortened vertical
// timing so several frames fit in a short run, PIPE_DLY=2.
module tb_vga_timing_out;

    localparam int CLK_DIV   = 4;
    localparam int H_ACTIVE  = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_ACTIVE  = 2;
    localparam int V_FP      = 1;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 1;
    localparam int PIPE_DLY  = 2;
    localparam int H_TOTAL   = 800;
    localparam int V_TOTAL   = 6;
    localparam int FRAME_CLK = CLK_DIV * H_TOTAL * V_TOTAL;   // 19200

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    localparam exp_t IDLE = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] rgb_in = 12'h000;
    logic [9:0]  h_cnt, v_cnt;
    logic        valid, pix_tick, frame_start, hsync, vsync;
    logic [3:0]  vga_r, vga_g, vga_b;
`ifdef VGA_TEST_PATTERN_EN
    logic        pattern_sel = 1'b0;
`endif

    vga_timing_out #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .PIPE_DLY(PIPE_DLY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid), .pix_tick(pix_tick),
        .frame_start(frame_start), .hsync(hsync), .vsync(vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    bit   mode = 1'b0;      // 0: constant ABC, 1: rgb_in follows h_cnt

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference raster position, advanced independently of the DUT.
    int mdiv, mh, mv, cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdiv <= 0; mh <= 0; mv <= 0; cyc <= 0;
        end else begin
            cyc <= cyc + 1;
            if (mdiv == CLK_DIV - 1) begin
                mdiv <= 0;
                if (mh == H_TOTAL - 1) begin
                    mh <= 0;
                    mv <= (mv == V_TOTAL - 1) ? 0 : mv + 1;
                end else begin
                    mh <= mh + 1;
                end
            end else begin
                mdiv <= mdiv + 1;
            end
        end
    end

    // Stimulus + expectation push.
    bit   m_tick, m_valid, m_fs;
    exp_t e;
    int   fs_cnt = 0;
    int   last_fs_cyc = -1;
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            for (int i = 0; i < PIPE_DLY - 1; i++) sb.push_back(IDLE);
        end else begin
            m_tick  = (mdiv == CLK_DIV - 1);
            m_valid = (mh < H_ACTIVE) && (mv < V_ACTIVE);
            m_fs    = m_tick && (mh == H_TOTAL - 1) && (mv == V_TOTAL - 1);
            chk("pix_tick", pix_tick, m_tick);
            chk("h_cnt", h_cnt, mh);
            chk("v_cnt", v_cnt, mv);
            chk("valid", valid, m_valid);
            chk("frame_start", frame_start, m_fs);
            if (frame_start) begin
                fs_cnt++;
                last_fs_cyc = cyc;
                chk("frame_start_period", cyc % FRAME_CLK, FRAME_CLK - 1);
            end
            if (m_tick) begin
                e.hs  = !((mh >= H_ACTIVE + H_FP) && (mh < H_ACTIVE + H_FP + H_SYNC));
                e.vs  = !((mv >= V_ACTIVE + V_FP) && (mv < V_ACTIVE + V_FP + V_SYNC));
                e.rgb = m_valid ? (mode ? 12'(mh) : 12'hABC) : 12'h000;
                sb.push_back(e);
                rgb_in = mode ? {2'b00, h_cnt} : 12'hABC;
            end else begin
                rgb_in = 12'($urandom);   // must be ignored between ticks
            end
        end
    end

    // Monitor: pins change only on the edge ending a tick; pop one entry per tick.
    bit   tick_prev = 1'b0;
    int   hs_run = 0, vs_run = 0, hs_pulses = 0, vs_pulses = 0;
    exp_t got;
    always @(negedge clk) begin
        if (!rst_n) begin
            tick_prev = 1'b0;
            hs_run = 0;
            vs_run = 0;
        end else begin
            if (tick_prev) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_empty", 1, 0);
                end else begin
                    got = sb.pop_front();
                    chk("hsync_pin", hsync, got.hs);
                    chk("vsync_pin", vsync, got.vs);
                    chk("rgb_pins", {vga_r, vga_g, vga_b}, got.rgb);
                end
                if (!hsync) hs_run++;
                else if (hs_run != 0) begin
                    chk("hsync_width_ticks", hs_run, H_SYNC);
                    hs_pulses++;
                    hs_run = 0;
                end
                if (!vsync) vs_run++;
                else if (vs_run != 0) begin
                    chk("vsync_width_ticks", vs_run, V_SYNC * H_TOTAL);
                    vs_pulses++;
                    vs_run = 0;
                end
            end
            tick_prev = pix_tick;
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_hsync"}, hsync, 1);
        chk({tag, "_vsync"}, vsync, 1);
        chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
        chk({tag, "_h_cnt"}, h_cnt, 0);
        chk({tag, "_v_cnt"}, v_cnt, 0);
        chk({tag, "_valid"}, valid, 1);
        chk({tag, "_pix_tick"}, pix_tick, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk_reset_state("reset");
        #1 rst_n = 1'b1;

        // First tick on the 4th clock after release; h advances 0 -> 1 on it.
        repeat (2) @(posedge clk);
        @(negedge clk) chk("tick_before_4th_clk", pix_tick, 0);
        @(posedge clk);
        @(negedge clk);
        chk("first_tick", pix_tick, 1);
        chk("h_before_first_tick", h_cnt, 0);
        @(posedge clk);
        #1 chk("h_after_first_tick", h_cnt, 1);

        repeat (FRAME_CLK - 5) @(posedge clk);
        mode = 1'b1;
        repeat (FRAME_CLK) @(posedge clk);

        found = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            @(negedge clk);
            if (mh == 300 && mv == 1) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_reset_point", found, 1);
        chk("pins_live_before_reset", ({vga_r, vga_g, vga_b} != 12'h000), 1);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_state("midreset");
        @(posedge clk);
        #2 rst_n = 1'b1;

        repeat (FRAME_CLK + 40) @(posedge clk);
        @(negedge clk);
        chk("frame_start_count", fs_cnt, 3);
        chk("first_fs_after_reset_cyc", last_fs_cyc, FRAME_CLK - 1);
        chk("hsync_pulse_count", hs_pulses, 19);
        chk("vsync_pulse_count", vs_pulses, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
